// File: rtl/trapezoid_acc_pkg.sv
// Shared types and default constants for the trapezoid surface accumulator.
package trapezoid_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  localparam int unsigned SEG_COUNT_DEF = 64;
  localparam int unsigned ACC_W_DEF     = 48;
  localparam int unsigned SURF_W        = 32;

endpackage

// File: rtl/trapezoid_surf_accumulator_adder.sv
// Combinational accumulator adder with carry flag.
// TRAPEZOID_ACC_SATURATE_EN selects clamping to all-ones on carry; otherwise wraps.
module surf_acc_adder
  import trapezoid_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [SURF_W-1:0] surf_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] full_sum;

  always_comb begin
    full_sum = {1'b0, acc_i} + (ACC_W+1)'(surf_i);
    carry_o  = full_sum[ACC_W];
`ifdef TRAPEZOID_ACC_SATURATE_EN
    // Once clamped, any further non-zero addend carries again, so the value sticks.
    sum_o    = carry_o ? '1 : full_sum[ACC_W-1:0];
`else
    sum_o    = full_sum[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/trapezoid_surf_accumulator.sv
// Sums SEG_COUNT trapezoid surfaces per frame and offers the integral on a valid/ready port.
// Overflow handling follows TRAPEZOID_ACC_SATURATE_EN (see surf_acc_adder).
module trapezoid_surf_accumulator
  import trapezoid_acc_pkg::*;
#(
  parameter int unsigned SEG_COUNT = SEG_COUNT_DEF,
  parameter int unsigned ACC_W     = ACC_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [SURF_W-1:0]              surf,
  input  logic                           surf_valid,
  input  logic                           out_ready,
  output logic [ACC_W-1:0]               integral,
  output logic                           integral_valid,
  output logic                           busy,
  output logic [$clog2(SEG_COUNT+1)-1:0] seg_cnt,
  output logic                           overflow
);

  localparam int unsigned CNT_W = $clog2(SEG_COUNT + 1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] integral_q, integral_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_seg;
  logic             clr;

  surf_acc_adder #(
    .ACC_W (ACC_W)
  ) u_adder (
    .acc_i   (acc_q),
    .surf_i  (surf),
    .sum_o   (sum),
    .carry_o (carry)
  );

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign last_seg = (cnt_inc == CNT_W'(SEG_COUNT));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    integral_d = integral_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    clr        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        // A restart wins over a sample arriving in the same cycle.
        if (start) begin
          clr = 1'b1;
        end else if (surf_valid) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | carry;
          if (last_seg) begin
            integral_d = sum;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (start) begin
            state_d = ACCUM;
            clr     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      integral_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      integral_q <= integral_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign integral       = integral_q;
  assign integral_valid = (state_q == HOLD);
  assign busy           = (state_q == ACCUM);
  assign seg_cnt        = cnt_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_trapezoid_surf_accumulator.sv
// Scoreboard bench: two instances (ACC_W=48 and ACC_W=33, SEG_COUNT=4) share one stimulus stream.
module tb_trapezoid_surf_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] surf;
  logic        surf_valid;
  logic        out_ready;

  logic [47:0] int48;
  logic        iv48, busy48, ovf48;
  logic [2:0]  cnt48;
  logic [32:0] int33;
  logic        iv33, busy33, ovf33;
  logic [2:0]  cnt33;

  typedef struct {
    logic [63:0] val;
    logic        ovf;
  } exp_t;

  exp_t q48[$];
  exp_t q33[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef TRAPEZOID_ACC_SATURATE_EN
  localparam logic [63:0] EXP_OVF33 = 64'h1_FFFF_FFFF;
`else
  localparam logic [63:0] EXP_OVF33 = 64'h1_FFFF_FFFC;
`endif

  trapezoid_surf_accumulator #(.SEG_COUNT(4), .ACC_W(48)) dut48 (
    .clk(clk), .rst(rst), .start(start), .surf(surf), .surf_valid(surf_valid),
    .out_ready(out_ready), .integral(int48), .integral_valid(iv48), .busy(busy48),
    .seg_cnt(cnt48), .overflow(ovf48)
  );

  trapezoid_surf_accumulator #(.SEG_COUNT(4), .ACC_W(33)) dut33 (
    .clk(clk), .rst(rst), .start(start), .surf(surf), .surf_valid(surf_valid),
    .out_ready(out_ready), .integral(int33), .integral_valid(iv33), .busy(busy33),
    .seg_cnt(cnt33), .overflow(ovf33)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare whenever a result is presented; pop on the accepting cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (iv48) begin
          if (q48.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected48: got 0x%0h expected no result", int48);
          end else begin
            chk("integral48", 64'(int48), q48[0].val);
            chk("ovf48", 64'(ovf48), 64'(q48[0].ovf));
            if (out_ready) void'(q48.pop_front());
          end
        end
        if (iv33) begin
          if (q33.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected33: got 0x%0h expected no result", int33);
          end else begin
            chk("integral33", 64'(int33), q33[0].val);
            chk("ovf33", 64'(ovf33), 64'(q33[0].ovf));
            if (out_ready) void'(q33.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [63:0] v48, input logic o48,
                            input logic [63:0] v33, input logic o33);
    exp_t e;
    e.val = v48; e.ovf = o48; q48.push_back(e);
    e.val = v33; e.ovf = o33; q33.push_back(e);
  endtask

  task automatic send(input logic [31:0] v);
    surf = v; surf_valid = 1'b1;
    @(posedge clk); #1;
    surf_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (q48.size() != 0 || q33.size() != 0); i++) idle(1);
    chk("drain48", 64'(q48.size()), 64'd0);
    chk("drain33", 64'(q33.size()), 64'd0);
  endtask

  logic [31:0] v4 [4];

  initial begin
    v4 = '{32'd8, 32'd16, 32'd24, 32'd32};
    rst = 1'b1; start = 1'b0; surf = '0; surf_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("rst_integral", 64'(int48), 64'd0);
    chk("rst_valid", 64'(iv48), 64'd0);
    chk("rst_busy", 64'(busy48), 64'd0);
    chk("rst_segcnt", 64'(cnt48), 64'd0);
    chk("rst_ovf", 64'(ovf48), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Normal back-to-back frame
    pulse_start();
    push_frame(64'd80, 1'b0, 64'd80, 1'b0);
    send(8); send(16); send(24);
    chk("early_valid48", 64'(iv48), 64'd0);
    send(32);
    chk("latency48", 64'(iv48), 64'd1);
    chk("latency33", 64'(iv33), 64'd1);
    drain();

    // Gapped frame: busy stays high, seg_cnt steps 1..4
    pulse_start();
    chk("gap_busy0", 64'(busy48), 64'd1);
    chk("gap_cnt0", 64'(cnt48), 64'd0);
    push_frame(64'd80, 1'b0, 64'd80, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(v4[i]);
      chk("gap_cnt", 64'(cnt48), 64'(i + 1));
      chk("gap_busy", 64'(busy48), (i < 3) ? 64'd1 : 64'd0);
      if (i < 3) begin
        idle(2);
        chk("gap_busy_idle", 64'(busy48), 64'd1);
      end
    end
    drain();

    // Backpressure: held result ignores samples and a lone start
    out_ready = 1'b0;
    pulse_start();
    push_frame(64'd80, 1'b0, 64'd80, 1'b0);
    for (int i = 0; i < 4; i++) send(v4[i]);
    for (int i = 0; i < 5; i++) begin
      surf = 32'd100; surf_valid = 1'b1; start = (i == 2);
      @(posedge clk); #1;
      chk("bp_cnt", 64'(cnt48), 64'd4);
      chk("bp_busy", 64'(busy48), 64'd0);
      chk("bp_valid", 64'(iv48), 64'd1);
    end
    surf_valid = 1'b0; start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_valid_drop", 64'(iv48), 64'd0);
    chk("bp_idle_busy", 64'(busy48), 64'd0);
    idle(1);
    chk("bp_still_idle", 64'(iv48), 64'd0);
    drain();

    // Restart mid-frame; sample in the restart cycle is dropped
    pulse_start();
    send(50); send(50);
    start = 1'b1; surf = 32'd999; surf_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; surf_valid = 1'b0;
    chk("restart_cnt", 64'(cnt48), 64'd0);
    chk("restart_busy", 64'(busy48), 64'd1);
    push_frame(64'd40, 1'b0, 64'd40, 1'b0);
    repeat (4) send(10);
    drain();

    // Overflow: only the 33-bit instance carries
    pulse_start();
    push_frame(64'h3_FFFF_FFFC, 1'b0, EXP_OVF33, 1'b1);
    repeat (4) send(32'hFFFF_FFFF);
    drain();

    // Asynchronous reset between edges mid-frame
    pulse_start();
    send(5); send(5);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_integral48", 64'(int48), 64'd0);
    chk("arst_integral33", 64'(int33), 64'd0);
    chk("arst_busy", 64'(busy48), 64'd0);
    chk("arst_cnt", 64'(cnt48), 64'd0);
    chk("arst_ovf33", 64'(ovf33), 64'd0);
    chk("arst_valid", 64'(iv48), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    surf = 32'd7; surf_valid = 1'b1;
    idle(3);
    surf_valid = 1'b0;
    chk("post_rst_busy", 64'(busy48), 64'd0);
    chk("post_rst_cnt", 64'(cnt48), 64'd0);
    chk("post_rst_valid", 64'(iv48), 64'd0);
    pulse_start();
    push_frame(64'd80, 1'b0, 64'd80, 1'b0);
    for (int i = 0; i < 4; i++) send(v4[i]);
    drain();

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trapezoid_surf_accumulator.md
# trapezoid_surf_accumulator

Downstream consumer of the trapezoid surface stage: it sums a fixed number of consecutive `surf` values (one trapezoid segment each) into a single integral. It then presents that integral on a valid/ready output port. It sits between the trapezoid surface calculator and the result readout/UART path. It turns a per-segment stream into one per-frame integral result.

## Interface
- `SEG_COUNT`, 64: segments summed per frame; must be ≥1.
- `ACC_W`, 48: accumulator and result width; must be ≥32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: clears the accumulator and begins a frame.
- `surf` in 32: segment surface from the upstream stage, unsigned.
- `surf_valid` in 1: qualifies `surf`; connects to the upstream `valid`.
- `out_ready` in 1: downstream accepts the result.
- `integral` out ACC_W: frame sum, held stable while `integral_valid` is high.
- `integral_valid` out 1: result available.
- `busy` out 1: high in the ACCUM state.
- `seg_cnt` out $clog2(SEG_COUNT+1): number of segments accepted in the current frame.
- `overflow` out 1: sticky; the accumulator exceeded ACC_W bits this frame.

## Operation
- The FSM has three states: IDLE, ACCUM and HOLD. Reset enters IDLE.
- **IDLE**
  - `start` → ACCUM, with acc=0, seg_cnt=0 and overflow=0.
  - `surf_valid` is ignored.
- **ACCUM**
  - Each cycle with `surf_valid`: acc += zero-extended `surf`, and seg_cnt++.
  - When the accepted sample makes seg_cnt equal to SEG_COUNT: latch acc+surf into `integral`, then go to HOLD.
  - `start` in ACCUM restarts the frame: acc=0, seg_cnt=0, overflow=0. A `surf_valid` in that same cycle is dropped.
- **HOLD**
  - `integral_valid`=1. `integral`, `seg_cnt` and `overflow` are frozen.
  - `surf_valid` is ignored.
  - `out_ready` → IDLE. If `start` is also high in that cycle → ACCUM with cleared state.
  - `start` without `out_ready` is ignored.
- **Arithmetic**
  - Addition is ACC_W+1 bits wide.
  - A carry out of bit ACC_W-1 sets `overflow`.
  - The result is handled per the configuration macro (see Configuration).

## Timing
- Reset values:
  - `integral` = 0
  - `integral_valid` = 0
  - `busy` = 0
  - `seg_cnt` = 0
  - `overflow` = 0
- Latency: the final `surf_valid` at edge t gives `integral_valid`=1 from edge t+1.
- No bubbles in ACCUM: back-to-back `surf_valid` is accepted every cycle.
- Result handshake:
  - The transfer occurs on the edge where `integral_valid` && `out_ready`.
  - `integral_valid` drops on the following cycle unless a new frame completes. This cannot happen within 1 cycle, so it always drops.
- `rst` mid-frame or mid-HOLD: immediate return to IDLE with all outputs at their reset values. The pending result is lost.
- SEG_COUNT=1: a single `surf_valid` in ACCUM goes straight to HOLD.

## Configuration
- `TRAPEZOID_ACC_SATURATE_EN` defined: on overflow the accumulator clamps to 2^ACC_W−1 and stays there for the rest of the frame.
- Not defined: the accumulator wraps modulo 2^ACC_W.
- `overflow` is set in both builds.

## Structure
- Package `trapezoid_acc_pkg` holds:
  - the state enum `acc_state_t` (IDLE, ACCUM, HOLD);
  - the default constants `SEG_COUNT_DEF`=64 and `ACC_W_DEF`=48.
- One sub-module, `surf_acc_adder`: a combinational ACC_W-bit adder with a carry flag, including the saturating/wrapping selection under the macro.
- FSM, counter and output registers stay in the top module.

## Test plan
- Normal frame (SEG_COUNT=4): `start`, then `surf` 8, 16, 24, 32 on consecutive cycles → `integral`=80, `integral_valid` high one cycle after the 4th sample, `overflow`=0.
- Gapped input (SEG_COUNT=4): the same values with 2 idle cycles between samples → `integral`=80; `busy` high throughout ACCUM; `seg_cnt` steps 1..4.
- Backpressure: `out_ready`=0 for 5 cycles in HOLD while `surf_valid`=1 with `surf`=100 → `integral` stays 80; after `out_ready` pulses → IDLE, `integral_valid`=0.
- Restart (SEG_COUNT=4): after 2 samples of 50, assert `start`, then 4 samples of 10 → `integral`=40.
- Overflow (ACC_W=33, SEG_COUNT=4): 4×0xFFFFFFFF → `overflow`=1, and `integral`=0x1FFFFFFFF with the macro or 0x1FFFFFFFC without it.
- Async reset: assert `rst` mid-ACCUM, between clock edges → all outputs are 0 immediately; a subsequent `surf_valid` is ignored until `start`.
